// File: rtl/z16_pkg.sv
// Shared definitions for the Z16 write-back path: register-file geometry,
// the write-back request record and the arbitration source selector.
package z16_pkg;

   localparam int REG_ADDR_W = 4;
   localparam int XLEN       = 16;
   localparam int NUM_REGS   = 16;

   // One register-file write: destination register and the value to store.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd_addr;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   localparam int WB_REQ_W = $bits(wb_req_t);

   // Which source owns the register-file write port in a given cycle.
   typedef enum logic [1:0] {
      SEL_IDLE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LOAD = 2'd2
   } wb_sel_t;

   // One-hot decode of a register address, used to build hazard masks.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
      logic [NUM_REGS-1:0] mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/z16_sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Besides the usual push/pop
// interface it exposes every storage slot and a per-slot valid flag so the
// parent can build masks over the buffered contents.
module z16_sync_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count,
   output logic [DEPTH-1:0]             entry_valid,
   output logic [DEPTH-1:0][WIDTH-1:0]  entries
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   cnt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == FULL_CNT);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage array write port.
   // NOTE: the data array is deliberately not reset; a slot is only observed when its valid flag is set.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Slot taps: a slot is valid when its distance from the head is below the occupancy.
   always_comb begin
      logic [PTR_W-1:0] offset;
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      offset      = '0;
      entry_valid = '0;
      entries     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset         = PTR_W'(i) - rd_ptr;
         entry_valid[i] = ({1'b0, offset} < cnt);
         entries[i]     = mem[i];
      end
   end

endmodule

// File: rtl/z16_writeback_unit.sv
// Write-back initiator for the Z16 register file. Merges single-cycle ALU
// results (high priority) with buffered load results into one registered
// write port, bounds load starvation, and exports a pending-load mask.
module z16_writeback_unit
   import z16_pkg::*;
#(
   parameter int LD_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_alu_valid,
   input  logic [REG_ADDR_W-1:0] i_alu_rd_addr,
   input  logic [XLEN-1:0]       i_alu_data,
   output logic                  o_alu_stall,
   input  logic                  i_ld_valid,
   output logic                  o_ld_ready,
   input  logic [REG_ADDR_W-1:0] i_ld_rd_addr,
   input  logic [XLEN-1:0]       i_ld_data,
   output logic [REG_ADDR_W-1:0] o_rd_addr,
   output logic                  o_rd_wen,
   output logic [XLEN-1:0]       o_rd_data,
   output logic [NUM_REGS-1:0]   o_ld_pending
);

   localparam int             STARVE_W   = $clog2(STARVE_MAX + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam int             CNT_W      = $clog2(LD_DEPTH) + 1;

   logic [STARVE_W-1:0]                starve_cnt;
   logic [STARVE_W-1:0]                starve_nxt;
   wb_sel_t                            sel;
   logic                               fifo_push;
   logic                               fifo_pop;
   wb_req_t                            fifo_wdata;
   logic [WB_REQ_W-1:0]                fifo_rdata;
   logic                               fifo_full;
   logic                               fifo_empty;
   logic [CNT_W-1:0]                   fifo_count;
   logic [LD_DEPTH-1:0]                fifo_entry_valid;
   logic [LD_DEPTH-1:0][WB_REQ_W-1:0]  fifo_entries;
   logic                               stall_raw;
   wb_req_t                            win_req;
   logic [NUM_REGS-1:0]                pending_raw;

   // Load results are accepted whenever the buffer has room; no bypass path.
   assign o_ld_ready         = !fifo_full && !i_rst;
   assign fifo_push          = i_ld_valid && o_ld_ready;
   assign fifo_wdata.rd_addr = i_ld_rd_addr;
   assign fifo_wdata.data    = i_ld_data;

   z16_sync_fifo #(
      .WIDTH (WB_REQ_W),
      .DEPTH (LD_DEPTH)
   ) u_ld_fifo (
      .clk         (i_clk),
      .rst         (i_rst),
      .push        (fifo_push),
      .pop         (fifo_pop),
      .wdata       (fifo_wdata),
      .rdata       (fifo_rdata),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .entry_valid (fifo_entry_valid),
      .entries     (fifo_entries)
   );

   // Arbitration: forced load drain, else ALU, else load, else idle.
   always_comb begin
      sel        = SEL_IDLE;
      fifo_pop   = 1'b0;
      stall_raw  = 1'b0;
      starve_nxt = '0;
      if (!fifo_empty && (starve_cnt == STARVE_LIM)) begin
         sel       = SEL_LOAD;
         fifo_pop  = 1'b1;
         stall_raw = i_alu_valid;
      end else if (i_alu_valid) begin
         sel = SEL_ALU;
         if ((fifo_count != '0) && (starve_cnt != STARVE_LIM)) begin
            starve_nxt = starve_cnt + 1'b1;
         end else begin
            starve_nxt = starve_cnt;
         end
      end else if (!fifo_empty) begin
         sel      = SEL_LOAD;
         fifo_pop = 1'b1;
      end
   end

   assign o_alu_stall = stall_raw && !i_rst;

   // Winning request presented to the output register.
   always_comb begin
      win_req = wb_req_t'(fifo_rdata);
      if (sel == SEL_ALU) begin
         win_req.rd_addr = i_alu_rd_addr;
         win_req.data    = i_alu_data;
      end
   end

   // Starve counter and registered write port; r0 writes are suppressed.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         starve_cnt <= '0;
         o_rd_addr  <= '0;
         o_rd_data  <= '0;
         o_rd_wen   <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         if (sel != SEL_IDLE) begin
            o_rd_addr <= win_req.rd_addr;
            o_rd_data <= win_req.data;
            o_rd_wen  <= (win_req.rd_addr != '0);
         end else begin
            o_rd_wen  <= 1'b0;
         end
      end
   end

   // Pending mask: OR of one-hot destinations over all buffered loads.
   always_comb begin
      wb_req_t entry;
      entry       = '0;
      pending_raw = '0;
      for (int i = 0; i < LD_DEPTH; i++) begin
         entry = wb_req_t'(fifo_entries[i]);
         if (fifo_entry_valid[i]) begin
            pending_raw = pending_raw | reg_onehot(entry.rd_addr);
         end
      end
   end

   assign o_ld_pending = i_rst ? '0 : pending_raw;

endmodule

// File: tb/tb_z16_writeback_unit.sv
// Directed bench for z16_writeback_unit: a cycle-by-cycle vector table with
// hand-computed expectations, followed by a hand-written starvation sequence.
module tb_z16_writeback_unit;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [3:0]  alu_rd_addr;
   logic [15:0] alu_data;
   logic        alu_stall;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_rd_addr;
   logic [15:0] ld_data;
   logic [3:0]  rd_addr;
   logic        rd_wen;
   logic [15:0] rd_data;
   logic [15:0] ld_pending;

   int n_checks = 0;
   int n_fail   = 0;

   z16_writeback_unit #(
      .LD_DEPTH   (2),
      .STARVE_MAX (4)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_alu_valid   (alu_valid),
      .i_alu_rd_addr (alu_rd_addr),
      .i_alu_data    (alu_data),
      .o_alu_stall   (alu_stall),
      .i_ld_valid    (ld_valid),
      .o_ld_ready    (ld_ready),
      .i_ld_rd_addr  (ld_rd_addr),
      .i_ld_data     (ld_data),
      .o_rd_addr     (rd_addr),
      .o_rd_wen      (rd_wen),
      .o_rd_data     (rd_data),
      .o_ld_pending  (ld_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle of stimulus: inputs, same-cycle combinational outputs,
   // and registered outputs seen after the rising edge.
   typedef struct {
      logic        rst;
      logic        av;
      logic [3:0]  ard;
      logic [15:0] adata;
      logic        lv;
      logic [3:0]  lrd;
      logic [15:0] ldata;
      logic        stall;
      logic        ready;
      logic [15:0] pend;
      logic        wen;
      logic [3:0]  waddr;
      logic [15:0] wdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic av, input logic [3:0] ard, input logic [15:0] ad,
                      input logic lv, input logic [3:0] lrd, input logic [15:0] ld,
                      input logic st, input logic rdy, input logic [15:0] pd,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd);
      vec_t v;
      v.rst = r;  v.av = av; v.ard = ard; v.adata = ad;
      v.lv = lv;  v.lrd = lrd; v.ldata = ld;
      v.stall = st; v.ready = rdy; v.pend = pd;
      v.wen = we; v.waddr = wa; v.wdata = wd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
      end
   endtask

   task automatic drive(input vec_t v);
      rst         = v.rst;
      alu_valid   = v.av;
      alu_rd_addr = v.ard;
      alu_data    = v.adata;
      ld_valid    = v.lv;
      ld_rd_addr  = v.lrd;
      ld_data     = v.ldata;
   endtask

   task automatic check_comb(input int idx, input vec_t v);
      check($sformatf("row%0d stall", idx),   {15'd0, alu_stall}, {15'd0, v.stall});
      check($sformatf("row%0d ready", idx),   {15'd0, ld_ready},  {15'd0, v.ready});
      check($sformatf("row%0d pending", idx), ld_pending,         v.pend);
   endtask

   task automatic check_regs(input int idx, input vec_t v);
      check($sformatf("row%0d wen", idx),   {15'd0, rd_wen},  {15'd0, v.wen});
      check($sformatf("row%0d waddr", idx), {12'd0, rd_addr}, {12'd0, v.waddr});
      check($sformatf("row%0d wdata", idx), rd_data,          v.wdata);
   endtask

   initial begin
      int cycles;
      int stall_cycle;
      bit found;

      rst = 1'b1; alu_valid = 1'b0; alu_rd_addr = '0; alu_data = '0;
      ld_valid = 1'b0; ld_rd_addr = '0; ld_data = '0;

      //   rst av ard  adata    lv lrd ldata     stall rdy pend      wen waddr wdata
      // Reset and idle
      add(1, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 0, 16'h0000, 0, 0,  16'h0000);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 0,  16'h0000);
      // ALU only
      add(0, 1, 3,  16'h1234, 0, 0,  16'h0000, 0, 1, 16'h0000, 1, 3,  16'h1234);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 3,  16'h1234);
      // Load fill under continuous ALU traffic, forced drains, blocked pushes when full
      add(0, 1, 10, 16'h0001, 1, 5,  16'hAAAA, 0, 1, 16'h0000, 1, 10, 16'h0001);
      add(0, 1, 10, 16'h0002, 1, 6,  16'hBBBB, 0, 1, 16'h0020, 1, 10, 16'h0002);
      add(0, 1, 10, 16'h0003, 1, 14, 16'hEEEE, 0, 0, 16'h0060, 1, 10, 16'h0003);
      add(0, 1, 10, 16'h0004, 1, 14, 16'hEEEE, 0, 0, 16'h0060, 1, 10, 16'h0004);
      add(0, 1, 10, 16'h0005, 1, 14, 16'hEEEE, 0, 0, 16'h0060, 1, 10, 16'h0005);
      add(0, 1, 10, 16'h0006, 1, 14, 16'hEEEE, 1, 0, 16'h0060, 1, 5,  16'hAAAA);
      add(0, 1, 10, 16'h0006, 0, 0,  16'h0000, 0, 1, 16'h0040, 1, 10, 16'h0006);
      add(0, 1, 10, 16'h0007, 0, 0,  16'h0000, 0, 1, 16'h0040, 1, 10, 16'h0007);
      add(0, 1, 10, 16'h0008, 0, 0,  16'h0000, 0, 1, 16'h0040, 1, 10, 16'h0008);
      add(0, 1, 10, 16'h0009, 0, 0,  16'h0000, 0, 1, 16'h0040, 1, 10, 16'h0009);
      add(0, 1, 10, 16'h000A, 0, 0,  16'h0000, 1, 1, 16'h0040, 1, 6,  16'hBBBB);
      add(0, 1, 10, 16'h000A, 0, 0,  16'h0000, 0, 1, 16'h0000, 1, 10, 16'h000A);
      // Idle drain of a single load
      add(0, 0, 0,  16'h0000, 1, 7,  16'h00FF, 0, 1, 16'h0000, 0, 10, 16'h000A);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0080, 1, 7,  16'h00FF);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 7,  16'h00FF);
      // Register 0 from both sources
      add(0, 1, 0,  16'hFFFF, 1, 0,  16'h5555, 0, 1, 16'h0000, 0, 0,  16'hFFFF);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0001, 0, 0,  16'h5555);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 0,  16'h5555);
      // Simultaneous push/pop at count 1
      add(0, 0, 0,  16'h0000, 1, 1,  16'h0101, 0, 1, 16'h0000, 0, 0,  16'h5555);
      add(0, 0, 0,  16'h0000, 1, 2,  16'h0202, 0, 1, 16'h0002, 1, 1,  16'h0101);
      add(0, 0, 0,  16'h0000, 1, 3,  16'h0303, 0, 1, 16'h0004, 1, 2,  16'h0202);
      add(0, 0, 0,  16'h0000, 1, 4,  16'h0404, 0, 1, 16'h0008, 1, 3,  16'h0303);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0010, 1, 4,  16'h0404);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 4,  16'h0404);
      // Reset with a full FIFO and a valid ALU result
      add(0, 1, 9,  16'h0900, 1, 11, 16'hB0B0, 0, 1, 16'h0000, 1, 9,  16'h0900);
      add(0, 1, 9,  16'h0901, 1, 12, 16'hC0C0, 0, 1, 16'h0800, 1, 9,  16'h0901);
      add(1, 1, 9,  16'h0902, 1, 13, 16'hD0D0, 0, 0, 16'h0000, 0, 0,  16'h0000);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 0,  16'h0000);
      add(0, 0, 0,  16'h0000, 0, 0,  16'h0000, 0, 1, 16'h0000, 0, 0,  16'h0000);
      add(0, 1, 15, 16'hF00F, 0, 0,  16'h0000, 0, 1, 16'h0000, 1, 15, 16'hF00F);

      foreach (vecs[i]) begin
         @(negedge clk);
         if (i > 0) check_regs(i - 1, vecs[i-1]);
         drive(vecs[i]);
         #1;
         check_comb(i, vecs[i]);
      end
      @(negedge clk);
      check_regs(vecs.size() - 1, vecs[vecs.size()-1]);

      // Starvation bound: one load behind a continuous ALU stream must be
      // written exactly STARVE_MAX+1 edges after its enqueue edge.
      rst = 1'b0; alu_valid = 1'b1; alu_rd_addr = 4'd2; alu_data = 16'h2222;
      ld_valid = 1'b1; ld_rd_addr = 4'd13; ld_data = 16'hDDDD;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      cycles = 0; stall_cycle = 0; found = 1'b0;
      while (!found && cycles < 10) begin
         @(negedge clk);
         if (alu_stall) stall_cycle = cycles + 1;
         @(posedge clk);
         #1;
         cycles++;
         found = rd_wen && (rd_addr == 4'd13);
      end
      check("starve load seen",    {15'd0, found},     16'd1);
      check("starve latency",      16'(cycles),        16'd5);
      check("starve stall cycle",  16'(stall_cycle),   16'd5);
      check("starve load data",    rd_data,            16'hDDDD);
      @(posedge clk);
      #1;
      check("held alu wen",  {15'd0, rd_wen},  16'd1);
      check("held alu addr", {12'd0, rd_addr}, 16'd2);
      check("held alu data", rd_data,          16'h2222);
      alu_valid = 1'b0;
      @(posedge clk);
      #1;
      check("final idle wen", {15'd0, rd_wen}, 16'd0);
      check("final pending",  ld_pending,      16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
